// File: rtl/e203_exu_longp_rob_if.sv
// rtl/e203_exu_longp_rob_if.sv - dispatch, completion and writeback bundle of the long-pipe ROB
interface e203_exu_longp_rob_if #(
    parameter int TAG_W = 2,
    parameter int XLEN  = 32
);
    logic             disp_i_valid;
    logic             disp_i_ready;
    logic             disp_i_rdwen;
    logic [4:0]       disp_i_rdidx;
    logic             disp_i_rdfpu;
    logic [TAG_W-1:0] disp_o_itag;
    logic             lsu_cmt_i_valid;
    logic [TAG_W-1:0] lsu_cmt_i_itag;
    logic [XLEN-1:0]  lsu_cmt_i_wdat;
    logic             lsu_cmt_i_err;
    logic             mdv_cmt_i_valid;
    logic [TAG_W-1:0] mdv_cmt_i_itag;
    logic [XLEN-1:0]  mdv_cmt_i_wdat;
    logic [4:0]       mdv_cmt_i_flags;
    logic             longp_wbck_o_valid;
    logic             longp_wbck_o_ready;
    logic [XLEN-1:0]  longp_wbck_o_wdat;
    logic [4:0]       longp_wbck_o_flags;
    logic [4:0]       longp_wbck_o_rdidx;
    logic             longp_wbck_o_rdfpu;
    logic             longp_excp_o_valid;
    logic             rob_empty;

    modport master (
        input  disp_i_valid, disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu,
        input  lsu_cmt_i_valid, lsu_cmt_i_itag, lsu_cmt_i_wdat, lsu_cmt_i_err,
        input  mdv_cmt_i_valid, mdv_cmt_i_itag, mdv_cmt_i_wdat, mdv_cmt_i_flags,
        input  longp_wbck_o_ready,
        output disp_i_ready, disp_o_itag,
        output longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_flags,
        output longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_excp_o_valid, rob_empty
    );

    modport slave (
        output disp_i_valid, disp_i_rdwen, disp_i_rdidx, disp_i_rdfpu,
        output lsu_cmt_i_valid, lsu_cmt_i_itag, lsu_cmt_i_wdat, lsu_cmt_i_err,
        output mdv_cmt_i_valid, mdv_cmt_i_itag, mdv_cmt_i_wdat, mdv_cmt_i_flags,
        output longp_wbck_o_ready,
        input  disp_i_ready, disp_o_itag,
        input  longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_flags,
        input  longp_wbck_o_rdidx, longp_wbck_o_rdfpu, longp_excp_o_valid, rob_empty
    );
endinterface

// File: rtl/e203_exu_longp_rob.sv
// rtl/e203_exu_longp_rob.sv - in-order retirement buffer for long-pipe results
module e203_exu_longp_rob #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    e203_exu_longp_rob_if.master  io
);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d, err_q, err_d;
    logic [DEPTH-1:0] rdwen_q, rdwen_d, rdfpu_q, rdfpu_d;
    logic [4:0]       rdidx_q [DEPTH];
    logic [4:0]       rdidx_d [DEPTH];
    logic [4:0]       flags_q [DEPTH];
    logic [4:0]       flags_d [DEPTH];
    logic [XLEN-1:0]  wdat_q  [DEPTH];
    logic [XLEN-1:0]  wdat_d  [DEPTH];

    logic full, push, pop, head_ok, wb_req, excp, silent, lsu_hit, mdv_hit;

    always_comb begin
        head_ok = alloc_q[head_q] & done_q[head_q];
        wb_req  = head_ok & rdwen_q[head_q] & ~err_q[head_q];
        excp    = head_ok & err_q[head_q];
        silent  = head_ok & ~rdwen_q[head_q] & ~err_q[head_q];
        pop     = excp | silent | (wb_req & io.longp_wbck_o_ready);
        full    = (count_q == CNT_W'(DEPTH));
        push    = io.disp_i_valid & ~full;
        lsu_hit = io.lsu_cmt_i_valid & alloc_q[io.lsu_cmt_i_itag] & ~done_q[io.lsu_cmt_i_itag];
        // LSU has priority when both units report the same tag
        mdv_hit = io.mdv_cmt_i_valid & alloc_q[io.mdv_cmt_i_itag] & ~done_q[io.mdv_cmt_i_itag]
                  & ~(lsu_hit & (io.lsu_cmt_i_itag == io.mdv_cmt_i_itag));

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        alloc_d = alloc_q;
        done_d  = done_q;
        err_d   = err_q;
        rdwen_d = rdwen_q;
        rdfpu_d = rdfpu_q;
        rdidx_d = rdidx_q;
        flags_d = flags_q;
        wdat_d  = wdat_q;

        if (lsu_hit) begin
            done_d[io.lsu_cmt_i_itag]  = 1'b1;
            err_d[io.lsu_cmt_i_itag]   = io.lsu_cmt_i_err;
            wdat_d[io.lsu_cmt_i_itag]  = io.lsu_cmt_i_wdat;
            flags_d[io.lsu_cmt_i_itag] = 5'd0;
        end
        if (mdv_hit) begin
            done_d[io.mdv_cmt_i_itag]  = 1'b1;
            err_d[io.mdv_cmt_i_itag]   = 1'b0;
            wdat_d[io.mdv_cmt_i_itag]  = io.mdv_cmt_i_wdat;
            flags_d[io.mdv_cmt_i_itag] = io.mdv_cmt_i_flags;
        end
        // pop and push never target the same slot: push needs !full, pop needs a live head
        if (pop) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            err_d[tail_q]   = 1'b0;
            rdwen_d[tail_q] = io.disp_i_rdwen;
            rdfpu_d[tail_q] = io.disp_i_rdfpu;
            rdidx_d[tail_q] = io.disp_i_rdidx;
            tail_d          = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // payload is only observed through alloc/done, so it needs no reset
    always_ff @(posedge clk) begin
        rdwen_q <= rdwen_d;
        rdfpu_q <= rdfpu_d;
        rdidx_q <= rdidx_d;
        flags_q <= flags_d;
        wdat_q  <= wdat_d;
    end

    assign io.disp_i_ready       = ~full;
    assign io.disp_o_itag        = tail_q;
    assign io.rob_empty          = (count_q == '0);
    assign io.longp_excp_o_valid = excp;
    assign io.longp_wbck_o_valid = wb_req;
    assign io.longp_wbck_o_wdat  = wb_req ? wdat_q[head_q]  : '0;
    assign io.longp_wbck_o_flags = wb_req ? flags_q[head_q] : 5'd0;
    assign io.longp_wbck_o_rdidx = wb_req ? rdidx_q[head_q] : 5'd0;
    assign io.longp_wbck_o_rdfpu = wb_req & rdfpu_q[head_q];
endmodule

// File: tb/tb_e203_exu_longp_rob.sv
// tb/tb_e203_exu_longp_rob.sv - randomized and directed bench for e203_exu_longp_rob
module tb_e203_exu_longp_rob;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e203_exu_longp_rob_if #(.TAG_W(2), .XLEN(32)) bus ();

    e203_exu_longp_rob #(.DEPTH(DEPTH), .TAG_W(2), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [1:0]  tag;
        bit          rdwen;
        logic [4:0]  rdidx;
        bit          rdfpu;
        bit          done;
        bit          err;
        logic [31:0] wdat;
        logic [4:0]  flags;
    } ent_t;

    ent_t       mq[$];
    logic [1:0] mtail;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.disp_i_valid       = 0;
        bus.disp_i_rdwen       = 0;
        bus.disp_i_rdidx       = 0;
        bus.disp_i_rdfpu       = 0;
        bus.lsu_cmt_i_valid    = 0;
        bus.lsu_cmt_i_itag     = 0;
        bus.lsu_cmt_i_wdat     = 0;
        bus.lsu_cmt_i_err      = 0;
        bus.mdv_cmt_i_valid    = 0;
        bus.mdv_cmt_i_itag     = 0;
        bus.mdv_cmt_i_wdat     = 0;
        bus.mdv_cmt_i_flags    = 0;
        bus.longp_wbck_o_ready = 1;
    endtask

    function automatic void complete(input logic [1:0] t, input logic [31:0] d,
                                     input bit e, input logic [4:0] f);
        foreach (mq[i])
            if (mq[i].tag == t && !mq[i].done) begin
                mq[i].done  = 1;
                mq[i].err   = e;
                mq[i].wdat  = d;
                mq[i].flags = f;
            end
    endfunction

    // reference: queue in dispatch order; head retires when done
    function automatic void model_update();
        bit   do_pop;
        int   size_pre;
        ent_t ne;
        if (rst) begin
            mq.delete();
            mtail = 0;
            return;
        end
        size_pre = mq.size();
        do_pop = 0;
        if (size_pre > 0 && mq[0].done)
            do_pop = mq[0].err || !mq[0].rdwen || bus.longp_wbck_o_ready;
        if (bus.lsu_cmt_i_valid)
            complete(bus.lsu_cmt_i_itag, bus.lsu_cmt_i_wdat, bus.lsu_cmt_i_err, 5'd0);
        if (bus.mdv_cmt_i_valid)
            complete(bus.mdv_cmt_i_itag, bus.mdv_cmt_i_wdat, 1'b0, bus.mdv_cmt_i_flags);
        if (do_pop) void'(mq.pop_front());
        if (bus.disp_i_valid && size_pre < DEPTH) begin
            ne = '{tag: mtail, rdwen: bus.disp_i_rdwen, rdidx: bus.disp_i_rdidx,
                   rdfpu: bus.disp_i_rdfpu, done: 0, err: 0, wdat: 0, flags: 0};
            mq.push_back(ne);
            mtail = mtail + 2'd1;
        end
    endfunction

    task automatic compare_outputs();
        bit ev, ex, rf;
        logic [31:0] wd;
        logic [4:0] fl, ri;
        ev = 0; ex = 0; rf = 0; wd = 0; fl = 0; ri = 0;
        if (mq.size() > 0 && mq[0].done) begin
            if (mq[0].err) ex = 1;
            else if (mq[0].rdwen) begin
                ev = 1; wd = mq[0].wdat; fl = mq[0].flags; ri = mq[0].rdidx; rf = mq[0].rdfpu;
            end
        end
        check("disp_ready", bus.disp_i_ready, mq.size() < DEPTH);
        check("itag", bus.disp_o_itag, mtail);
        check("rob_empty", bus.rob_empty, mq.size() == 0);
        check("wbck_valid", bus.longp_wbck_o_valid, ev);
        check("wbck_wdat", bus.longp_wbck_o_wdat, wd);
        check("wbck_flags", bus.longp_wbck_o_flags, fl);
        check("wbck_rdidx", bus.longp_wbck_o_rdidx, ri);
        check("wbck_rdfpu", bus.longp_wbck_o_rdfpu, rf);
        check("excp_valid", bus.longp_excp_o_valid, ex);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic dispatch(input bit wen, input logic [4:0] idx, input bit fpu);
        bus.disp_i_valid = 1; bus.disp_i_rdwen = wen; bus.disp_i_rdidx = idx; bus.disp_i_rdfpu = fpu;
    endtask

    task automatic lsu(input logic [1:0] t, input logic [31:0] d, input bit e);
        bus.lsu_cmt_i_valid = 1; bus.lsu_cmt_i_itag = t; bus.lsu_cmt_i_wdat = d; bus.lsu_cmt_i_err = e;
    endtask

    task automatic mdv(input logic [1:0] t, input logic [31:0] d, input logic [4:0] f);
        bus.mdv_cmt_i_valid = 1; bus.mdv_cmt_i_itag = t; bus.mdv_cmt_i_wdat = d; bus.mdv_cmt_i_flags = f;
    endtask

    function automatic logic [1:0] pick_tag();
        if (mq.size() > 0 && $urandom_range(3) != 0)
            return mq[$urandom_range(mq.size() - 1)].tag;
        return 2'($urandom_range(3));
    endfunction

    logic [1:0] base;

    initial begin
        idle_inputs();
        mtail = 0;
        rst = 1;
        cycle();
        rst = 0;
        check("reset_ready", bus.disp_i_ready, 1);
        check("reset_empty", bus.rob_empty, 1);

        // single mdv writeback
        dispatch(1, 5'd5, 0);
        cycle();
        idle_inputs();
        mdv(2'd0, 32'h1234_5678, 5'h03);
        cycle();
        idle_inputs();
        check("t1_valid", bus.longp_wbck_o_valid, 1);
        check("t1_rdidx", bus.longp_wbck_o_rdidx, 5'd5);
        check("t1_wdat", bus.longp_wbck_o_wdat, 32'h1234_5678);
        check("t1_flags", bus.longp_wbck_o_flags, 5'h03);
        cycle();
        check("t1_empty", bus.rob_empty, 1);

        // fill, complete out of order, drain in order
        base = mtail;
        for (int i = 0; i < 4; i++) begin
            dispatch(1, 5'(10 + i), 0);
            cycle();
        end
        idle_inputs();
        check("t2_full", bus.disp_i_ready, 0);
        lsu(base + 2'd3, 32'h33, 0); cycle();
        lsu(base + 2'd1, 32'h11, 0); cycle();
        lsu(base + 2'd2, 32'h22, 0); cycle();
        check("t2_hold", bus.longp_wbck_o_valid, 0);
        lsu(base, 32'h00, 0); cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            check("t2_order", bus.longp_wbck_o_rdidx, 5'(10 + i));
            cycle();
        end

        // stall with ready low
        dispatch(1, 5'd20, 1); cycle();
        dispatch(1, 5'd21, 0); cycle();
        idle_inputs();
        bus.longp_wbck_o_ready = 0;
        mdv(mtail - 2'd2, 32'hCAFE_0001, 5'h1F); cycle();
        bus.mdv_cmt_i_valid = 0;
        mdv(mtail - 2'd1, 32'hCAFE_0002, 5'h02); cycle();
        idle_inputs();
        bus.longp_wbck_o_ready = 0;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_rdidx", bus.longp_wbck_o_rdidx, 5'd20);
            cycle();
        end
        bus.longp_wbck_o_ready = 1;
        cycle();
        check("t3_next", bus.longp_wbck_o_rdidx, 5'd21);
        cycle();

        // error entry retires as exception
        base = mtail;
        for (int i = 0; i < 3; i++) begin
            dispatch(1, 5'(24 + i), 0);
            cycle();
        end
        idle_inputs();
        lsu(base + 2'd1, 32'hDEAD, 1); cycle();
        lsu(base + 2'd2, 32'hBEEF, 0); cycle();
        lsu(base, 32'h600D, 0); cycle();
        idle_inputs();
        cycle();
        check("t4_excp", bus.longp_excp_o_valid, 1);
        cycle();
        check("t4_after", bus.longp_wbck_o_rdidx, 5'd26);
        cycle();

        // same-tag collision: LSU wins
        base = mtail;
        dispatch(1, 5'd7, 0); cycle();
        idle_inputs();
        lsu(base, 32'hAAAA_AAAA, 0);
        mdv(base, 32'h5555_5555, 5'h1F);
        cycle();
        idle_inputs();
        check("t5_wdat", bus.longp_wbck_o_wdat, 32'hAAAA_AAAA);
        check("t5_flags", bus.longp_wbck_o_flags, 0);
        cycle();

        // reset mid-operation
        base = mtail;
        bus.longp_wbck_o_ready = 0;
        for (int i = 0; i < 3; i++) begin
            dispatch(1, 5'(1 + i), 0);
            cycle();
        end
        idle_inputs();
        bus.longp_wbck_o_ready = 0;
        mdv(base, 32'h1, 5'h0); lsu(base + 2'd1, 32'h2, 0); cycle();
        idle_inputs();
        rst = 1; cycle(); rst = 0;
        check("t6_empty", bus.rob_empty, 1);
        lsu(base, 32'h9, 0); mdv(base + 2'd2, 32'h8, 5'h1); cycle();
        idle_inputs();
        cycle();
        check("t6_nowb", bus.longp_wbck_o_valid, 0);

        // random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(2) != 0) dispatch($urandom_range(4) != 0, 5'($urandom), 1'($urandom));
            if ($urandom_range(1) != 0) lsu(pick_tag(), $urandom, $urandom_range(5) == 0);
            if ($urandom_range(1) != 0) mdv(pick_tag(), $urandom, 5'($urandom));
            bus.longp_wbck_o_ready = ($urandom_range(3) != 0);
            cycle();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
